// File: rtl/iris_mem_pkg.sv
// iris_mem_pkg -- shared definitions for the iris memory arbiter.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default word and word-address widths
//   BE_WIDTH                        : byte-enable width for the default word
//   state_t                         : arbiter FSM states
//   port_t                          : requester identity (instruction / data)
package iris_mem_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

endpackage

// File: rtl/iris_arb_pick.sv
// iris_arb_pick -- two-requester grant selection.
//   i_req, d_req : pending requests from the instruction and data ports
//   last_grant   : port granted on the previous acceptance
//   grant        : one-hot grant, [0] = instruction, [1] = data
// On conflict the port that was not granted last wins; a caller that pins
// last_grant to PORT_I obtains fixed data-port priority.
module iris_arb_pick
  import iris_mem_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  port_t      last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (i_req && d_req) begin
      if (last_grant == PORT_D) grant[0] = 1'b1;
      else                      grant[1] = 1'b1;
    end else begin
      grant[0] = i_req;
      grant[1] = d_req;
    end
  end

endmodule

// File: rtl/iris_mem_arbiter.sv
// iris_mem_arbiter -- shares one synchronous memory between an instruction
// read port and a data read/write port, one transaction in flight at a time.
//   clk, rst                       : clock, asynchronous active-high reset
//   i_req/i_addr                   : instruction read request
//   i_ready/i_done/i_rdata         : accept strobe, completion pulse, read data
//   d_req/d_we/d_addr/d_wdata/d_be : data request (read or byte-masked write)
//   d_ready/d_done/d_rdata         : accept strobe, completion pulse, read data
//   mem_*                          : registered memory interface, mem_rdata in
// Build option: define IRIS_ARB_RR_EN for round-robin arbitration on
// conflict; otherwise the data port always wins.
module iris_mem_arbiter
  import iris_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LAT     = 2
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ready,
  output logic                    i_done,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_ready,
  output logic                    d_done,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    mem_we,
  output logic                    mem_ce,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

  state_t     state, state_nxt;
  port_t      port_q;
  port_t      last_grant;
  logic [3:0] cnt;
  logic [1:0] grant;
  logic       accept_i, accept_d, accept;

`ifdef IRIS_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= PORT_I;
    else if (accept) last_grant <= accept_d ? PORT_D : PORT_I;
  end
`else
  // Pinning last_grant to the instruction port makes the picker favour data.
  assign last_grant = PORT_I;
`endif

  iris_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign i_ready  = (state == ST_IDLE) && !rst && grant[0];
  assign d_ready  = (state == ST_IDLE) && !rst && grant[1];
  assign accept_i = i_req && i_ready;
  assign accept_d = d_req && d_ready;
  assign accept   = accept_i || accept_d;

  assign i_done = (state == ST_RESP) && (port_q == PORT_I);
  assign d_done = (state == ST_RESP) && (port_q == PORT_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // WAIT spans RD_LAT cycles; mem_rdata is captured on its final cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = mem_we ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The mem_* registers double as the captured request; mem_we in ACCESS
  // therefore steers the FSM between the write and read paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      port_q    <= PORT_I;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '1;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_ce <= accept;
      mem_we <= accept_d && d_we;
      if (accept_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
        port_q    <= PORT_D;
      end else if (accept_i) begin
        mem_addr  <= i_addr;
        mem_be    <= '1;
        port_q    <= PORT_I;
      end
      if (state == ST_ACCESS)
        cnt <= CNT_LOAD;
      else if (state == ST_WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == ST_WAIT && cnt == '0) begin
        if (port_q == PORT_I) i_rdata <= mem_rdata;
        else                  d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_iris_mem_arbiter.sv
// tb_iris_mem_arbiter -- randomized bench for iris_mem_arbiter.
// Two instances (RD_LAT=2 and RD_LAT=1) share all inputs; sel picks which
// one is observed. A transaction-level model predicts grants, done cycles,
// memory strobes and read data from acceptance times.
// Honours IRIS_ARB_RR_EN the same way the design does.
module tb_iris_mem_arbiter;

  localparam int DW = iris_mem_pkg::DEF_DATA_WIDTH;
  localparam int AW = iris_mem_pkg::DEF_ADDR_WIDTH;
  localparam int BW = iris_mem_pkg::BE_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [BW-1:0] d_be = '0;

  logic          i_ready_v[2], i_done_v[2], d_ready_v[2], d_done_v[2];
  logic          mem_we_v[2], mem_ce_v[2];
  logic [DW-1:0] i_rdata_v[2], d_rdata_v[2], mem_wdata_v[2];
  logic [AW-1:0] mem_addr_v[2];
  logic [BW-1:0] mem_be_v[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    iris_mem_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RD_LAT     (g == 0 ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ready   (i_ready_v[g]),
      .i_done    (i_done_v[g]),
      .i_rdata   (i_rdata_v[g]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_ready   (d_ready_v[g]),
      .d_done    (d_done_v[g]),
      .d_rdata   (d_rdata_v[g]),
      .mem_addr  (mem_addr_v[g]),
      .mem_wdata (mem_wdata_v[g]),
      .mem_be    (mem_be_v[g]),
      .mem_we    (mem_we_v[g]),
      .mem_ce    (mem_ce_v[g]),
      .mem_rdata (mem_rdata)
    );
  end

  always #5 clk = ~clk;

  int unsigned n_vec = 0, n_err = 0;
  int          cyc = 0;
  bit          sel = 1'b0;
  bit          fix_en = 1'b0;
  logic [DW-1:0] fix_val = '0;

  // Model state
  bit            i_pend = 1'b0, d_pend = 1'b0;
  bit            cur_port = 1'b0, cur_we = 1'b0;
  int            cur_acc = -10, cur_done = -1, cur_samp = -1;
  logic [BW-1:0] cur_be = '0;
  logic [DW-1:0] cur_wdata = '0, cur_rd = '0, m_i_rdata = '0, m_d_rdata = '0;
  logic [AW-1:0] last_addr = '0;
`ifdef IRIS_ARB_RR_EN
  bit            lg = 1'b0;  // 0 = instruction granted last, 1 = data
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, lat sel %0d)", tag, got, exp, cyc, sel);
    end
  endtask

  task automatic check_cycle();
    int lat;
    bit idle, gi, gd, acc, done;
    lat  = sel ? 1 : 2;
    idle = (cyc > cur_done);
    gi = 1'b0;
    gd = 1'b0;
    if (idle) begin
      if (i_pend && d_pend) begin
`ifdef IRIS_ARB_RR_EN
        if (lg) gi = 1'b1; else gd = 1'b1;
`else
        gd = 1'b1;
`endif
      end else begin
        gi = i_pend;
        gd = d_pend;
      end
    end
    acc  = (cyc == cur_acc + 1);
    done = (cyc == cur_done);
    if (done && !cur_we) begin
      if (cur_port) m_d_rdata = cur_rd;
      else          m_i_rdata = cur_rd;
    end
    check_eq("i_ready", 32'(i_ready_v[sel]), 32'(gi));
    check_eq("d_ready", 32'(d_ready_v[sel]), 32'(gd));
    check_eq("mem_ce", 32'(mem_ce_v[sel]), 32'(acc));
    check_eq("mem_we", 32'(mem_we_v[sel]), 32'(acc && cur_we));
    check_eq("mem_addr", 32'(mem_addr_v[sel]), 32'(last_addr));
    if (acc && cur_port) begin
      check_eq("mem_be", 32'(mem_be_v[sel]), 32'(cur_be));
      check_eq("mem_wdata", 32'(mem_wdata_v[sel]), 32'(cur_wdata));
    end
    check_eq("i_done", 32'(i_done_v[sel]), 32'(done && !cur_port));
    check_eq("d_done", 32'(d_done_v[sel]), 32'(done && cur_port));
    check_eq("i_rdata", 32'(i_rdata_v[sel]), 32'(m_i_rdata));
    check_eq("d_rdata", 32'(d_rdata_v[sel]), 32'(m_d_rdata));
    if (gi || gd) begin
      cur_port  = gd;
      cur_we    = gd ? d_we : 1'b0;
      cur_acc   = cyc;
      cur_done  = cyc + 2 + (cur_we ? 0 : lat);
      cur_samp  = cyc + 1 + lat;
      last_addr = gd ? d_addr : i_addr;
      cur_be    = d_be;
      cur_wdata = d_wdata;
`ifdef IRIS_ARB_RR_EN
      lg = gd;
`endif
      if (gd) d_pend = 1'b0;
      else    i_pend = 1'b0;
    end
  endtask

  task automatic run_cycles(input int n, input int rate);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = 1'b0;
      if (!i_pend && $urandom_range(99) < rate) begin
        i_pend = 1'b1;
        i_addr = AW'($urandom);
      end
      if (!d_pend && $urandom_range(99) < rate) begin
        d_pend  = 1'b1;
        d_we    = 1'($urandom_range(1));
        d_addr  = AW'($urandom);
        d_wdata = DW'($urandom);
        d_be    = BW'($urandom);
      end
      i_req = i_pend;
      d_req = d_pend;
      mem_rdata = fix_en ? fix_val : DW'($urandom);
      if (!cur_we && cyc == cur_samp) cur_rd = mem_rdata;
      #1;
      check_cycle();
      cyc++;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      i_req = i_pend;
      d_req = d_pend;
      #1;
      check_eq("rst_i_ready", 32'(i_ready_v[sel]), 32'd0);
      check_eq("rst_d_ready", 32'(d_ready_v[sel]), 32'd0);
      check_eq("rst_i_done", 32'(i_done_v[sel]), 32'd0);
      check_eq("rst_d_done", 32'(d_done_v[sel]), 32'd0);
      check_eq("rst_mem_ce", 32'(mem_ce_v[sel]), 32'd0);
      check_eq("rst_mem_we", 32'(mem_we_v[sel]), 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr_v[sel]), 32'd0);
      check_eq("rst_mem_wdata", 32'(mem_wdata_v[sel]), 32'd0);
      check_eq("rst_mem_be", 32'(mem_be_v[sel]), 32'((1 << BW) - 1));
      check_eq("rst_i_rdata", 32'(i_rdata_v[sel]), 32'd0);
      check_eq("rst_d_rdata", 32'(d_rdata_v[sel]), 32'd0);
      cyc++;
    end
    cur_acc   = -10;
    cur_done  = -1;
    cur_samp  = -1;
    cur_we    = 1'b0;
    last_addr = '0;
    m_i_rdata = '0;
    m_d_rdata = '0;
`ifdef IRIS_ARB_RR_EN
    lg = 1'b0;
`endif
  endtask

  task automatic issue_i(input logic [AW-1:0] a);
    i_pend = 1'b1;
    i_addr = a;
  endtask

  task automatic issue_d(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be);
    d_pend  = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_be    = be;
  endtask

  initial begin
    // RD_LAT = 2 instance
    sel = 1'b0;
    do_reset(2);
    fix_en  = 1'b1;
    fix_val = 24'hABCDEF;
    issue_i(16'h0040);
    run_cycles(6, 0);
    check_eq("single_read_rdata", 32'(i_rdata_v[sel]), 32'hABCDEF);
    fix_en = 1'b0;
    issue_d(1'b1, 16'h1234, 24'h00FF00, 3'b010);
    run_cycles(4, 0);
    run_cycles(30, 100);
    run_cycles(20, 0);
    run_cycles(400, 40);
    run_cycles(20, 0);
    // Reset while a read sits in WAIT, with a new request held across it
    issue_i(16'h0bad);
    run_cycles(3, 0);
    issue_i(16'h0c0d);
    do_reset(2);
    run_cycles(8, 0);

    // RD_LAT = 1 instance
    sel = 1'b1;
    do_reset(2);
    fix_en  = 1'b1;
    fix_val = 24'h5A5A5A;
    issue_i(16'h0041);
    run_cycles(5, 0);
    check_eq("lat1_read_rdata", 32'(i_rdata_v[sel]), 32'h5A5A5A);
    fix_en = 1'b0;
    run_cycles(300, 40);
    run_cycles(30, 100);
    run_cycles(20, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
